// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS main control: state codes, opcode/funct
// values, ALU control codes and datapath mux selects.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_LOAD_IR   = 4'd2,
    S_DECODE    = 4'd3,
    S_MEM_ADDR  = 4'd4,
    S_MEM_READ  = 4'd5,
    S_MEM_WB    = 4'd6,
    S_MEM_WRITE = 4'd7,
    S_EXECUTE   = 4'd8,
    S_ALU_WB    = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_BRANCH    = 4'd12,
    S_JUMP      = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALU control codes, shared with the datapath ALU
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       reg_dst;
    logic       mem_read;
    logic       memto_reg;
    logic [3:0] alu_ctrl;
    logic       mem_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
  } ctrl_t;

  function automatic logic is_mem_wait(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bus between the main control FSM (master) and the MIPS datapath (slave).
interface multicycle_control_if #(
  parameter int unsigned COUNT_WIDTH = 32
);
  logic [31:0]            instruction;
  logic                   memReady;
  logic                   RegDst;
  logic                   MemRead;
  logic                   MemtoReg;
  logic [3:0]             ALUCtrl;
  logic                   MemWrite;
  logic                   ALUSrcA;
  logic [1:0]             ALUSrcB;
  logic                   RegWrite;
  logic                   IorD;
  logic                   IRWrite;
  logic                   PCWrite;
  logic                   PCWriteCond;
  logic [1:0]             PCSource;
  logic                   illegalInstr;
  logic                   busError;
  logic [COUNT_WIDTH-1:0] instrRetired;
  logic [3:0]             state;

  modport master (
    input  instruction, memReady,
    output RegDst, MemRead, MemtoReg, ALUCtrl, MemWrite, ALUSrcA, ALUSrcB,
           RegWrite, IorD, IRWrite, PCWrite, PCWriteCond, PCSource,
           illegalInstr, busError, instrRetired, state
  );

  modport slave (
    output instruction, memReady,
    input  RegDst, MemRead, MemtoReg, ALUCtrl, MemWrite, ALUSrcA, ALUSrcB,
           RegWrite, IorD, IRWrite, PCWrite, PCWriteCond, PCSource,
           illegalInstr, busError, instrRetired, state
  );
endinterface

// File: rtl/multicycle_control_alu_decode.sv
// R-type funct decoder: maps funct to the ALU control code and flags unsupported values.
module multicycle_control_alu_decode
  import multicycle_control_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [3:0] alu_ctrl_o,
  output logic       legal_o
);

  // funct lookup; unknown codes fall back to add and are marked illegal
  always_comb begin
    alu_ctrl_o = ALU_ADD;
    legal_o    = 1'b1;
    case (funct_i)
      FN_ADD:  alu_ctrl_o = ALU_ADD;
      FN_SUB:  alu_ctrl_o = ALU_SUB;
      FN_AND:  alu_ctrl_o = ALU_AND;
      FN_OR:   alu_ctrl_o = ALU_OR;
      FN_NOR:  alu_ctrl_o = ALU_NOR;
      FN_SLT:  alu_ctrl_o = ALU_SLT;
      default: begin
        alu_ctrl_o = ALU_ADD;
        legal_o    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control FSM. Control outputs are decoded from the next state
// and registered on the same edge as the state, so write strobes are glitch-free.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_control_if.master bus
);

  localparam logic [3:0] TIMEOUT_C = 4'(MEM_TIMEOUT);

  state_t                 state_q, state_d;
  ctrl_t                  ctrl_q, ctrl_d;
  logic [3:0]             wait_q, wait_d;
  logic                   illegal_q, illegal_d;
  logic                   bus_err_q, bus_err_d;
  logic [COUNT_WIDTH-1:0] retired_q, retired_d;

  logic [5:0] opcode_s;
  logic [5:0] funct_s;
  logic [3:0] exec_alu_s;
  logic       funct_legal_s;
  logic [3:0] wait_inc_s;
  logic       timeout_s;
  logic       retire_s;
  logic       unused_instr_s;

  assign opcode_s       = bus.instruction[31:26];
  assign funct_s        = bus.instruction[5:0];
  assign unused_instr_s = ^bus.instruction[25:6];

  multicycle_control_alu_decode u_alu_decode (
    .funct_i    (funct_s),
    .alu_ctrl_o (exec_alu_s),
    .legal_o    (funct_legal_s)
  );

  // Moore output table; ALU_WB keeps the ALU code chosen in EXECUTE
  function automatic ctrl_t state_ctrl(input state_t s, input logic [3:0] exec_alu,
                                       input logic [3:0] held_alu);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: c.mem_read = 1'b1;
      S_LOAD_IR: begin
        c.ir_write  = 1'b1;
        c.pc_write  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_ctrl  = ALU_ADD;
        c.pc_source = PCSRC_ALU;
      end
      S_DECODE: begin
        c.alu_src_b = SRCB_IMM_SH2;
        c.alu_ctrl  = ALU_ADD;
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_ctrl  = ALU_ADD;
      end
      S_MEM_READ: begin
        c.mem_read  = 1'b1;
        c.iord      = 1'b1;
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_ctrl  = ALU_ADD;
      end
      S_MEM_WRITE: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_ctrl  = ALU_ADD;
      end
      S_MEM_WB: begin
        c.reg_write = 1'b1;
        c.memto_reg = 1'b1;
      end
      S_EXECUTE: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_REG;
        c.alu_ctrl  = exec_alu;
      end
      S_ALU_WB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
        c.alu_ctrl  = held_alu;
      end
      S_ADDI_WB: c.reg_write = 1'b1;
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SRCB_REG;
        c.alu_ctrl      = ALU_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = PCSRC_JUMP;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  assign wait_inc_s = wait_q + 4'd1;
  assign timeout_s  = !bus.memReady && (wait_inc_s == TIMEOUT_C);

  // Next-state, wait counter and pulse decode; wait_d stays non-zero only while waiting
  always_comb begin
    state_d   = state_q;
    wait_d    = 4'd0;
    illegal_d = 1'b0;
    bus_err_d = 1'b0;
    retire_s  = 1'b0;
    case (state_q)
      S_IDLE:    state_d = S_FETCH;
      S_FETCH: begin
        if (bus.memReady) begin
          state_d = S_LOAD_IR;
        end else if (timeout_s) begin
          bus_err_d = 1'b1;
        end else begin
          wait_d = wait_inc_s;
        end
      end
      S_LOAD_IR: state_d = S_DECODE;
      S_DECODE: begin
        case (opcode_s)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_ADDI:      state_d = S_ADDI_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_RTYPE: begin
            if (funct_legal_s) begin
              state_d = S_EXECUTE;
            end else begin
              state_d   = S_FETCH;
              illegal_d = 1'b1;
            end
          end
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: state_d = (opcode_s == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ: begin
        if (bus.memReady) begin
          state_d = S_MEM_WB;
        end else if (timeout_s) begin
          state_d   = S_FETCH;
          bus_err_d = 1'b1;
        end else begin
          wait_d = wait_inc_s;
        end
      end
      S_MEM_WRITE: begin
        if (bus.memReady) begin
          state_d  = S_FETCH;
          retire_s = 1'b1;
        end else if (timeout_s) begin
          state_d   = S_FETCH;
          bus_err_d = 1'b1;
        end else begin
          wait_d = wait_inc_s;
        end
      end
      S_EXECUTE:   state_d = S_ALU_WB;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      S_MEM_WB, S_ALU_WB, S_ADDI_WB, S_BRANCH, S_JUMP: begin
        state_d  = S_FETCH;
        retire_s = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and counter next values follow from the chosen next state
  always_comb begin
    ctrl_d    = state_ctrl(state_d, exec_alu_s, ctrl_q.alu_ctrl);
    retired_d = retire_s ? (retired_q + COUNT_WIDTH'(1)) : retired_q;
  end

  // State, registered outputs, wait counter and retire counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ctrl_q    <= '0;
      wait_q    <= 4'd0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
      retired_q <= retired_d;
    end
  end

  assign bus.RegDst       = ctrl_q.reg_dst;
  assign bus.MemRead      = ctrl_q.mem_read;
  assign bus.MemtoReg     = ctrl_q.memto_reg;
  assign bus.ALUCtrl      = ctrl_q.alu_ctrl;
  assign bus.MemWrite     = ctrl_q.mem_write;
  assign bus.ALUSrcA      = ctrl_q.alu_src_a;
  assign bus.ALUSrcB      = ctrl_q.alu_src_b;
  assign bus.RegWrite     = ctrl_q.reg_write;
  assign bus.IorD         = ctrl_q.iord;
  assign bus.IRWrite      = ctrl_q.ir_write;
  assign bus.PCWrite      = ctrl_q.pc_write;
  assign bus.PCWriteCond  = ctrl_q.pc_write_cond;
  assign bus.PCSource     = ctrl_q.pc_source;
  assign bus.illegalInstr = illegal_q;
  assign bus.busError     = bus_err_q;
  assign bus.instrRetired = retired_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench: a per-instruction reference model expands each instruction into
// the expected cycle-by-cycle control trace, which is compared against the DUT.
module tb_multicycle_control;

  typedef struct packed {
    logic [3:0] st;
    logic       reg_dst;
    logic       mem_read;
    logic       memto_reg;
    logic [3:0] alu;
    logic       mem_write;
    logic       src_a;
    logic [1:0] src_b;
    logic       reg_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_wc;
    logic [1:0] pc_src;
    logic       ill;
    logic       berr;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_control_if #(.COUNT_WIDTH(32)) bus ();

  multicycle_control #(.MEM_TIMEOUT(15), .COUNT_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  obs_t        exp_q[$];
  logic        rdy_q[$];
  logic [31:0] cnt_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] model_cnt;
  logic        pend_ill;
  logic        pend_berr;
  logic [5:0]  legal_fn [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};

  function automatic obs_t sample();
    obs_t a;
    a = {bus.state, bus.RegDst, bus.MemRead, bus.MemtoReg, bus.ALUCtrl, bus.MemWrite,
         bus.ALUSrcA, bus.ALUSrcB, bus.RegWrite, bus.IorD, bus.IRWrite, bus.PCWrite,
         bus.PCWriteCond, bus.PCSource, bus.illegalInstr, bus.busError};
    return a;
  endfunction

  function automatic obs_t blank(input logic [3:0] st);
    obs_t e;
    e = '0;
    e.st = st;
    return e;
  endfunction

  // {legal, alu code} for an R-type funct
  function automatic logic [4:0] funct_alu(input logic [5:0] fn);
    case (fn)
      6'h20:   return {1'b1, 4'b0010};
      6'h22:   return {1'b1, 4'b0110};
      6'h24:   return {1'b1, 4'b0000};
      6'h25:   return {1'b1, 4'b0001};
      6'h27:   return {1'b1, 4'b1100};
      6'h2A:   return {1'b1, 4'b0111};
      default: return 5'b0;
    endcase
  endfunction

  function automatic int spec_latency(input logic [31:0] instr, input int wf, input int wm);
    logic [5:0] op;
    logic [4:0] fa;
    int         base;
    op = instr[31:26];
    fa = funct_alu(instr[5:0]);
    if (op == 6'h23)      base = (wm >= 15) ? 19 : 6 + wm;
    else if (op == 6'h2B) base = (wm >= 15) ? 19 : 5 + wm;
    else if (op == 6'h00) base = fa[4] ? 5 : 3;
    else if (op == 6'h08) base = 5;
    else if (op == 6'h04 || op == 6'h02) base = 4;
    else base = 3;
    return base + wf;
  endfunction

  task automatic push(input obs_t e, input logic rdy);
    exp_q.push_back(e);
    rdy_q.push_back(rdy);
    cnt_q.push_back(model_cnt);
  endtask

  task automatic model_reset();
    model_cnt = 32'd0;
    pend_ill  = 1'b0;
    pend_berr = 1'b0;
    exp_q.delete();
    rdy_q.delete();
    cnt_q.delete();
  endtask

  // Expand one instruction into its expected trace (wf fetch waits, wm memory waits)
  task automatic build(input logic [31:0] instr, input int wf, input int wm);
    obs_t       e;
    logic [5:0] op;
    logic [4:0] fa;
    int         n;
    op = instr[31:26];
    fa = funct_alu(instr[5:0]);
    for (int i = 0; i <= wf; i++) begin
      e = blank(4'd1);
      e.mem_read = 1'b1;
      if (i == 0) begin
        e.ill  = pend_ill;
        e.berr = pend_berr;
      end
      push(e, i == wf);
    end
    pend_ill = 1'b0;
    pend_berr = 1'b0;
    e = blank(4'd2); e.ir_write = 1'b1; e.pc_write = 1'b1; e.src_b = 2'b01; e.alu = 4'b0010;
    push(e, 1'($urandom_range(0, 1)));
    e = blank(4'd3); e.src_b = 2'b11; e.alu = 4'b0010;
    push(e, 1'($urandom_range(0, 1)));
    if (op == 6'h23 || op == 6'h2B) begin
      e = blank(4'd4); e.src_a = 1'b1; e.src_b = 2'b10; e.alu = 4'b0010;
      push(e, 1'($urandom_range(0, 1)));
      e.st = (op == 6'h23) ? 4'd5 : 4'd7;
      e.mem_read = (op == 6'h23);
      e.mem_write = (op == 6'h2B);
      e.iord = 1'b1;
      n = (wm >= 15) ? 15 : wm;
      for (int i = 0; i < n; i++) push(e, 1'b0);
      if (wm >= 15) begin
        pend_berr = 1'b1;
      end else begin
        push(e, 1'b1);
        if (op == 6'h23) begin
          e = blank(4'd6); e.reg_write = 1'b1; e.memto_reg = 1'b1;
          push(e, 1'($urandom_range(0, 1)));
        end
        model_cnt++;
      end
    end else if (op == 6'h00 && fa[4]) begin
      e = blank(4'd8); e.src_a = 1'b1; e.alu = fa[3:0];
      push(e, 1'($urandom_range(0, 1)));
      e = blank(4'd9); e.reg_write = 1'b1; e.reg_dst = 1'b1; e.alu = fa[3:0];
      push(e, 1'($urandom_range(0, 1)));
      model_cnt++;
    end else if (op == 6'h08) begin
      e = blank(4'd10); e.src_a = 1'b1; e.src_b = 2'b10; e.alu = 4'b0010;
      push(e, 1'($urandom_range(0, 1)));
      e = blank(4'd11); e.reg_write = 1'b1;
      push(e, 1'($urandom_range(0, 1)));
      model_cnt++;
    end else if (op == 6'h04) begin
      e = blank(4'd12); e.src_a = 1'b1; e.alu = 4'b0110; e.pc_wc = 1'b1; e.pc_src = 2'b01;
      push(e, 1'($urandom_range(0, 1)));
      model_cnt++;
    end else if (op == 6'h02) begin
      e = blank(4'd13); e.pc_write = 1'b1; e.pc_src = 2'b10;
      push(e, 1'($urandom_range(0, 1)));
      model_cnt++;
    end else begin
      pend_ill = 1'b1;
    end
  endtask

  // Run one instruction from FETCH; limit >= 0 stops after that many cycles
  task automatic run_instr(input logic [31:0] instr, input int wf, input int wm, input int limit);
    obs_t        e, a;
    logic        r;
    logic [31:0] c;
    int          cycles;
    int          exp_lat;
    cycles = 0;
    exp_lat = spec_latency(instr, wf, wm);
    bus.instruction = instr;
    build(instr, wf, wm);
    while (exp_q.size() > 0 && (limit < 0 || cycles < limit)) begin
      e = exp_q.pop_front();
      r = rdy_q.pop_front();
      c = cnt_q.pop_front();
      a = sample();
      n_checks++;
      if (a !== e) begin
        n_errors++;
        $display("FAIL ctrl instr=%h cycle=%0d got=%h exp=%h", instr, cycles, a, e);
      end
      n_checks++;
      if (bus.instrRetired !== c) begin
        n_errors++;
        $display("FAIL retired instr=%h cycle=%0d got=%0d exp=%0d", instr, cycles,
                 bus.instrRetired, c);
      end
      bus.memReady = r;
      @(negedge clk);
      cycles++;
    end
    if (limit < 0) begin
      n_checks++;
      if (bus.state !== 4'd1 || cycles != exp_lat) begin
        n_errors++;
        $display("FAIL latency instr=%h state=%0d cycles=%0d exp_cycles=%0d", instr,
                 bus.state, cycles, exp_lat);
      end
    end
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    bus.memReady = 1'b1;
    bus.instruction = 32'h0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (sample() !== blank(4'd0) || bus.instrRetired !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_state got=%h retired=%0d exp=%h", sample(), bus.instrRetired,
               blank(4'd0));
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (sample() !== blank(4'd0)) begin
      n_errors++;
      $display("FAIL idle_after_release got=%h exp=%h", sample(), blank(4'd0));
    end
    @(negedge clk);
  endtask

  task automatic test_add();
    run_instr(32'h012A4020, 0, 0, -1);
    n_checks++;
    if (bus.instrRetired !== 32'd1) begin
      n_errors++;
      $display("FAIL add_retired got=%0d exp=1", bus.instrRetired);
    end
  endtask

  task automatic test_lw_wait();
    run_instr(32'h8D090004, 0, 3, -1);
    n_checks++;
    if (bus.instrRetired !== 32'd2) begin
      n_errors++;
      $display("FAIL lw_retired got=%0d exp=2", bus.instrRetired);
    end
  endtask

  task automatic test_branch_jump();
    run_instr(32'h11090003, 0, 0, -1);
    run_instr(32'h08000010, 0, 0, -1);
    n_checks++;
    if (bus.instrRetired !== 32'd4) begin
      n_errors++;
      $display("FAIL beq_j_retired got=%0d exp=4", bus.instrRetired);
    end
  endtask

  task automatic test_illegal();
    run_instr(32'hFC000000, 0, 0, -1);
    run_instr(32'h00000001, 1, 0, -1);
    n_checks++;
    if (bus.instrRetired !== 32'd4) begin
      n_errors++;
      $display("FAIL illegal_retired got=%0d exp=4", bus.instrRetired);
    end
  endtask

  task automatic test_timeout_and_reset();
    run_instr(32'hAD090008, 0, 15, -1);
    run_instr(32'h21090005, 0, 0, -1);
    n_checks++;
    if (bus.instrRetired !== 32'd5) begin
      n_errors++;
      $display("FAIL timeout_retired got=%0d exp=5", bus.instrRetired);
    end
    // stop partway through a stalled store, then reset between clock edges
    run_instr(32'hAD090008, 0, 20, 7);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.MemWrite !== 1'b0 || bus.state !== 4'd0 || bus.instrRetired !== 32'd0) begin
      n_errors++;
      $display("FAIL async_reset memwrite=%b state=%0d retired=%0d exp=0/0/0", bus.MemWrite,
               bus.state, bus.instrRetired);
    end
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_instr(32'h08000020, 0, 0, -1);
    n_checks++;
    if (bus.instrRetired !== 32'd1) begin
      n_errors++;
      $display("FAIL post_reset_retired got=%0d exp=1", bus.instrRetired);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] base;
    logic [31:0] instr;
    logic [5:0]  fn;
    int          k, wf, wm;
    for (int i = 0; i < 40; i++) begin
      base = $urandom;
      k = $urandom_range(0, 7);
      fn = legal_fn[$urandom_range(0, 5)];
      case (k)
        0:       instr = {6'h23, base[25:0]};
        1:       instr = {6'h2B, base[25:0]};
        2:       instr = {6'h00, base[25:6], fn};
        3:       instr = {6'h08, base[25:0]};
        4:       instr = {6'h04, base[25:0]};
        5:       instr = {6'h02, base[25:0]};
        6:       instr = {6'h30 | 6'($urandom_range(0, 15)), base[25:0]};
        default: instr = {6'h00, base[25:6], 6'($urandom_range(0, 31))};
      endcase
      wf = $urandom_range(0, 2);
      wm = ($urandom_range(0, 7) == 0) ? 15 + $urandom_range(0, 2) : $urandom_range(0, 3);
      run_instr(instr, wf, wm, -1);
    end
    n_checks++;
    if (bus.instrRetired !== model_cnt) begin
      n_errors++;
      $display("FAIL random_retired got=%0d exp=%0d", bus.instrRetired, model_cnt);
    end
  endtask

  initial begin
    bus.memReady = 1'b0;
    bus.instruction = 32'h0;
    test_reset();
    test_add();
    test_lw_wait();
    test_branch_jump();
    test_illegal();
    test_timeout_and_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
